rc4_search_coordinator: RTL

RC4_SEARCH_COORDINATOR -- requirements
Module: rc4_search_coordinator

---
 rtl/rc4_search_coordinator_pkg.sv | 21 ++
 rtl/rc4_search_coordinator_if.sv | 24 ++
 rtl/rc4_search_coordinator_arb.sv | 22 ++
 rtl/rc4_search_coordinator.sv | 116 +++++++++++
 4 files changed

// File: rtl/rc4_search_coordinator_pkg.sv
// Shared types and defaults for the RC4 key-search coordinator.
// Holds the FSM state encoding and the default key geometry.
package rc4_search_pkg;

    localparam int KEY_WIDTH_DEFAULT   = 24;
    localparam int SEARCH_BITS_DEFAULT = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SEARCH,
        ST_FOUND,
        ST_EXHAUSTED
    } search_state_t;

    // A single core still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc4_search_coordinator_if.sv
// Coordinator <-> decrypt-core bus: launch, slice bounds, halt, and per-core status.
// Launch/halt are single-level controls; status flags are sampled every cycle, no backpressure.
interface rc4_search_coordinator_if #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = 24
);
    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key_base;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key_limit;
    logic                           core_halt;
    logic [NUM_CORES-1:0]           core_found;
    logic [NUM_CORES-1:0]           core_not_found;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;

    modport master (
        output core_start, core_key_base, core_key_limit, core_halt,
        input  core_found, core_not_found, core_key
    );

    modport slave (
        input  core_start, core_key_base, core_key_limit, core_halt,
        output core_found, core_not_found, core_key
    );
endinterface

// File: rtl/rc4_search_coordinator_arb.sv
// Lowest-index-wins encoder over the per-core found flags.
// Latency: combinational. Backpressure: none.
module core_priority_arbiter
    import rc4_search_pkg::*;
#(
    parameter  int NUM_CORES = 4,
    localparam int IDX_W     = idx_width(NUM_CORES)
)(
    input  logic [NUM_CORES-1:0] req,
    output logic                 vld,
    output logic [IDX_W-1:0]     idx
);

    always_comb begin
        vld = |req;
        idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/rc4_search_coordinator.sv
// Splits the key space across NUM_CORES cores, launches them, collects the first hit or exhaustion.
// Latency: start -> core_start 1 cycle; core_found -> found 1 cycle. No backpressure; start ignored while busy.
// Optional search-duration counter enabled by macro RC4_SEARCH_CYCLE_COUNT_EN.
module rc4_search_coordinator
    import rc4_search_pkg::*;
#(
    parameter  int NUM_CORES   = 4,
    parameter  int KEY_WIDTH   = KEY_WIDTH_DEFAULT,
    parameter  int SEARCH_BITS = SEARCH_BITS_DEFAULT,
    localparam int IDX_W       = idx_width(NUM_CORES)
)(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    rc4_search_coordinator_if.master      cores,
    output logic                          busy,
    output logic                          found,
    output logic                          not_found,
    output logic [KEY_WIDTH-1:0]          found_key,
    output logic [IDX_W-1:0]              found_core,
    output logic [31:0]                   search_cycles
);

    localparam logic [63:0] SLICE = (64'd1 << SEARCH_BITS) / 64'(NUM_CORES);

    search_state_t        state;
    logic [NUM_CORES-1:0] done_mask;
    logic [NUM_CORES-1:0] done_next;
    logic                 arb_vld;
    logic [IDX_W-1:0]     arb_idx;

    // Slice bounds are elaboration-time constants.
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
        localparam logic [63:0] BASE  = 64'(g) * SLICE;
        localparam logic [63:0] LIMIT = BASE + SLICE - 64'd1;
        assign cores.core_key_base [g*KEY_WIDTH +: KEY_WIDTH] = BASE[KEY_WIDTH-1:0];
        assign cores.core_key_limit[g*KEY_WIDTH +: KEY_WIDTH] = LIMIT[KEY_WIDTH-1:0];
    end

    core_priority_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .req (cores.core_found),
        .vld (arb_vld),
        .idx (arb_idx)
    );

    assign done_next = done_mask | cores.core_not_found;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            done_mask        <= '0;
            found_key        <= '0;
            found_core       <= '0;
            cores.core_start <= '0;
            cores.core_halt  <= 1'b0;
            busy             <= 1'b0;
            found            <= 1'b0;
            not_found        <= 1'b0;
        end else begin
            cores.core_start <= '0;
            unique case (state)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (start) begin
                        state            <= ST_LAUNCH;
                        cores.core_start <= '1;
                        cores.core_halt  <= 1'b0;
                        busy             <= 1'b1;
                        found            <= 1'b0;
                        not_found        <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    state     <= ST_SEARCH;
                    done_mask <= '0;
                end
                ST_SEARCH: begin
                    done_mask <= done_next;
                    // A hit outranks a simultaneous final exhaustion.
                    if (arb_vld) begin
                        state           <= ST_FOUND;
                        found_key       <= cores.core_key[int'(arb_idx)*KEY_WIDTH +: KEY_WIDTH];
                        found_core      <= arb_idx;
                        found           <= 1'b1;
                        busy            <= 1'b0;
                        cores.core_halt <= 1'b1;
                    end else if (&done_next) begin
                        state           <= ST_EXHAUSTED;
                        not_found       <= 1'b1;
                        busy            <= 1'b0;
                        cores.core_halt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RC4_SEARCH_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else if (state == ST_LAUNCH) begin
            cycle_cnt <= '0;
        end else if (state == ST_SEARCH && cycle_cnt != 32'hFFFF_FFFF) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign search_cycles = cycle_cnt;
`else
    assign search_cycles = '0;
`endif

endmodule
